// File: rtl/counter_reporter_pkg.sv
// Shared constants and types for the counter reporter: frame geometry,
// flag bit positions and the serialiser state encoding.
package counter_reporter_pkg;

   localparam int unsigned FRAME_BYTES = 18;
   localparam logic [7:0]  HDR_DEFAULT = 8'hA5;

   localparam int unsigned OVF_BIT  = 2;
   localparam int unsigned CHG1_BIT = 1;
   localparam int unsigned CHG0_BIT = 0;

   // Snapshot entry layout: {flags[1:0], Count1, Count0}
   localparam int unsigned ENTRY_W = 130;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/counter_reporter_if.sv
// Byte-wide valid/ready stream carrying serialised snapshot frames.
interface counter_reporter_if;

   logic [7:0] Out_Data;
   logic       Out_Valid;
   logic       Out_Ready;

   modport master (output Out_Data, output Out_Valid, input Out_Ready);
   modport slave  (input Out_Data, input Out_Valid, output Out_Ready);

endinterface

// File: rtl/counter_reporter_snap_fifo.sv
// Synchronous FIFO with level output; a push is also accepted when full
// provided a pop happens on the same edge.
module snap_fifo #(
   parameter int unsigned WIDTH = 130,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/counter_reporter.sv
// Snapshots two 64-bit event counts on change, queues them, and streams each
// snapshot as an 18-byte frame with an in-band drop flag.
module counter_reporter
   import counter_reporter_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter logic [7:0]  HEADER = HDR_DEFAULT
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Sample_En,
   input  logic [63:0]             Count0,
   input  logic [63:0]             Count1,
   counter_reporter_if.master      out_if,
   output logic                    Overflow,
   output logic [$clog2(DEPTH):0]  Fifo_Level
);

   localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

   state_e             state_q, state_d;
   logic [4:0]         idx_q, idx_d;
   logic [7:0]         frame_q [FRAME_BYTES];
   logic [7:0]         frame_d [FRAME_BYTES];
   logic [63:0]        prev0_q, prev0_d;
   logic [63:0]        prev1_q, prev1_d;
   logic               overflow_q, overflow_d;

   logic               chg0, chg1, chg;
   logic               load, pop, drop;
   logic               fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

   assign chg0       = (Count0 != prev0_q);
   assign chg1       = (Count1 != prev1_q);
   assign chg        = Sample_En & (chg0 | chg1);
   assign fifo_wdata = {chg1, chg0, Count1, Count0};

   snap_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (Reset),
      .push_i  (chg),
      .pop_i   (pop),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .level_o (Fifo_Level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      frame_d          = frame_q;
      prev0_d          = prev0_q;
      prev1_d          = prev1_q;
      overflow_d       = overflow_q;
      load             = 1'b0;
      out_if.Out_Valid = 1'b0;
      out_if.Out_Data  = '0;

      if (chg) begin
         prev0_d = Count0;
         prev1_d = Count1;
      end

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         SEND: begin
            out_if.Out_Valid = 1'b1;
            out_if.Out_Data  = frame_q[idx_q];
            if (out_if.Out_Ready) begin
               if (idx_q == LAST_IDX) begin
                  if (!fifo_empty) load = 1'b1;
                  else             state_d = IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Loading captures the pre-edge Overflow into the frame's flag byte
      if (load) begin
         state_d    = SEND;
         idx_d      = '0;
         frame_d[0] = HEADER;
         frame_d[1] = '0;
         frame_d[1][OVF_BIT]  = overflow_q;
         frame_d[1][CHG1_BIT] = fifo_rdata[129];
         frame_d[1][CHG0_BIT] = fifo_rdata[128];
         for (int unsigned i = 0; i < 8; i++) begin
            frame_d[2 + i]  = fifo_rdata[i*8 +: 8];
            frame_d[10 + i] = fifo_rdata[64 + i*8 +: 8];
         end
      end

      if (drop)      overflow_d = 1'b1;
      else if (load) overflow_d = 1'b0;
   end

   assign pop  = load;
   assign drop = chg & fifo_full & ~pop;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         frame_q    <= '{default: '0};
         prev0_q    <= '0;
         prev1_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         prev0_q    <= prev0_d;
         prev1_q    <= prev1_d;
         overflow_q <= overflow_d;
      end
   end

   assign Overflow = overflow_q;

endmodule

// File: tb/tb_counter_reporter.sv
// Directed bench for counter_reporter: frame content, latency, backpressure,
// overflow flagging, back-to-back frames and asynchronous reset.
module tb_counter_reporter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Sample_En;
   logic [63:0] Count0, Count1;
   logic        Overflow;
   logic [2:0]  Fifo_Level;

   int total = 0;
   int bad   = 0;

   counter_reporter_if sif ();

   counter_reporter #(
      .DEPTH  (4),
      .HEADER (8'hA5)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Sample_En  (Sample_En),
      .Count0     (Count0),
      .Count1     (Count1),
      .out_if     (sif.master),
      .Overflow   (Overflow),
      .Fifo_Level (Fifo_Level)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [143:0] mk(input logic [7:0] fl, input logic [63:0] c0,
                                       input logic [63:0] c1);
      return {c1, c0, fl, 8'hA5};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Waits (bounded) for a frame, then accepts 18 bytes with Out_Ready high
   task automatic recv(output logic [143:0] f, output int waited, output bit ok);
      f      = '0;
      waited = 0;
      ok     = 1'b1;
      sif.Out_Ready = 1'b1;
      while (!sif.Out_Valid && waited < 20) begin
         tick();
         waited++;
      end
      for (int i = 0; i < 18; i++) begin
         if (!sif.Out_Valid) ok = 1'b0;
         f[i*8 +: 8] = sif.Out_Data;
         tick();
      end
   endtask

   initial begin
      logic [143:0] f;
      int           w;
      bit           ok;
      int           cnt;
      bit           hold_ok, seen, r;
      logic [7:0]   d;

      Reset = 1'b0; Sample_En = 1'b0; Count0 = '0; Count1 = '0; sif.Out_Ready = 1'b0;
      repeat (2) tick();
      chk("rst_valid", sif.Out_Valid, 0);
      chk("rst_data",  sif.Out_Data, 0);
      chk("rst_level", Fifo_Level, 0);
      chk("rst_ovf",   Overflow, 0);
      @(negedge Clk);
      Reset = 1'b1; Sample_En = 1'b1; sif.Out_Ready = 1'b1;
      tick();
      chk("idle_level", Fifo_Level, 0);

      // Single change: push at edge k, byte 0 valid after edge k+1
      Count0 = 64'd1;
      tick();
      chk("t1_k_valid", sif.Out_Valid, 0);
      chk("t1_k_level", Fifo_Level, 1);
      tick();
      chk("t1_k1_valid", sif.Out_Valid, 1);
      chk("t1_byte0",    sif.Out_Data, 8'hA5);
      recv(f, w, ok);
      chk("t1_frame", f, mk(8'h01, 64'd1, 64'd0));
      chk("t1_ok",    ok, 1);
      chk("t1_idle",  sif.Out_Valid, 0);

      // Both counters change together
      Count0 = 64'd5; Count1 = 64'd2;
      tick();
      recv(f, w, ok);
      chk("t2_wait",  w, 1);
      chk("t2_frame", f, mk(8'h03, 64'd5, 64'd2));
      chk("t2_ok",    ok, 1);

      // Backpressure with continuous changes: 6 loaded, 7..10 queued, 11..15 dropped
      sif.Out_Ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         Count0 = Count0 + 64'd1;
         tick();
      end
      chk("t3_level", Fifo_Level, 4);
      chk("t3_ovf",   Overflow, 1);
      chk("t3_hold",  sif.Out_Data, 8'hA5);
      recv(f, w, ok);
      chk("t3_f6",       f, mk(8'h01, 64'd6, 64'd2));
      chk("t3_ovf_clr",  Overflow, 0);
      chk("t3_level3",   Fifo_Level, 3);
      recv(f, w, ok);
      chk("t3_f7",       f, mk(8'h05, 64'd7, 64'd2));
      chk("t3_b2b_wait", w, 0);
      chk("t3_b2b_ok",   ok, 1);
      recv(f, w, ok);
      chk("t3_f8", f, mk(8'h01, 64'd8, 64'd2));
      recv(f, w, ok);
      recv(f, w, ok);
      chk("t3_f10",   f, mk(8'h01, 64'd10, 64'd2));
      chk("t3_empty", Fifo_Level, 0);
      chk("t3_idle",  sif.Out_Valid, 0);

      // Out_Ready toggling mid-frame
      Count0 = 64'd20;
      tick();
      tick();
      cnt = 0; hold_ok = 1'b1;
      for (int c = 0; c < 60 && cnt < 18; c++) begin
         r = (c % 2 == 0);
         sif.Out_Ready = r;
         d = sif.Out_Data;
         tick();
         if (r) begin
            f[cnt*8 +: 8] = d;
            cnt++;
         end else if (sif.Out_Data !== d || !sif.Out_Valid) begin
            hold_ok = 1'b0;
         end
      end
      chk("t4_count", cnt, 18);
      chk("t4_hold",  hold_ok, 1);
      chk("t4_frame", f, mk(8'h01, 64'd20, 64'd2));
      chk("t4_idle",  sif.Out_Valid, 0);
      sif.Out_Ready = 1'b1;

      // Async reset mid-frame with another entry queued
      Count0 = 64'd30;
      tick();
      tick();
      Count0 = 64'd31;
      repeat (7) tick();
      chk("t6_pre_valid", sif.Out_Valid, 1);
      chk("t6_pre_level", Fifo_Level, 1);
      #2 Reset = 1'b0;
      #1;
      chk("t6_rst_valid", sif.Out_Valid, 0);
      chk("t6_rst_data",  sif.Out_Data, 0);
      chk("t6_rst_level", Fifo_Level, 0);
      Count0 = '0; Count1 = '0;
      @(negedge Clk);
      Reset = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (sif.Out_Valid) seen = 1'b1;
      end
      chk("t6_no_residual", seen, 0);
      chk("t6_level",       Fifo_Level, 0);

      Count1 = 64'd3;
      tick();
      recv(f, w, ok);
      chk("t7_frame", f, mk(8'h02, 64'd0, 64'd3));

      // Sample_En low freezes Prev; re-enable compares against stale Prev
      Sample_En = 1'b0;
      Count0 = 64'd9;
      repeat (3) tick();
      chk("t8_level", Fifo_Level, 0);
      chk("t8_valid", sif.Out_Valid, 0);
      Sample_En = 1'b1;
      tick();
      recv(f, w, ok);
      chk("t8_frame", f, mk(8'h01, 64'd9, 64'd3));

      // Counter returning to zero is a change
      Count0 = 64'd0;
      tick();
      recv(f, w, ok);
      chk("t9_frame", f, mk(8'h01, 64'd0, 64'd3));
      chk("t9_ok",    ok, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_reporter.md
Name: counter_reporter

Overview:
- Downstream consumer of the dual 64-bit event counter stage (Output0 = enabled non-select cycles, Output1 = every fourth select cycle).
- Watches both counts and snapshots them whenever either changes, queueing each snapshot in a small FIFO.
- Serialises each snapshot as an 18-byte frame on a byte-wide valid/ready stream for the debug/UART link.
- Frame loss under backpressure is flagged in-band.

Parameters:
- DEPTH, 4, snapshot FIFO entries (power of two, ≥2).
- HEADER, 8'hA5, first byte of every frame.

Ports:
- Clk  input  1  sole clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- Sample_En  input  1  change detection is enabled while high.
- Count0  input  64  counter stage Output0.
- Count1  input  64  counter stage Output1.
- Out_Data  output  8  current frame byte.
- Out_Valid  output  1  Out_Data is valid.
- Out_Ready  input  1  sink accepts the byte on an edge where Out_Valid & Out_Ready.
- Overflow  output  1  sticky drop flag, for visibility only.
- Fifo_Level  output  $clog2(DEPTH)+1  current number of queued entries.

Behaviour:
- Reset (Reset==0, async) clears all of the following immediately, including mid-frame:
  - Prev0/Prev1 snapshot registers; FIFO pointers and Fifo_Level; Overflow.
  - FSM goes to IDLE, with Out_Valid=0 and Out_Data=0.
  - A partially sent frame is abandoned and is never resumed.
- Change detect, at each edge:
  - chg = Sample_En & ((Count0!=Prev0) | (Count1!=Prev1)).
  - On chg: Prev0/Prev1 <= Count0/Count1, and a push is attempted with entry {flags[1:0]={Count1!=Prev1, Count0!=Prev0}, Count1, Count0}.
  - Prev is updated even if the push is dropped.
- FIFO:
  - A push is accepted if the FIFO is not full, or if a pop occurs on the same edge; Fifo_Level is unchanged when both happen.
  - When the FIFO is full and there is no pop, the entry is dropped and Overflow <= 1.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - Out_Valid=0.
    - If the FIFO is non-empty at an edge: pop, load the frame register, set idx=0, and go to SEND.
  - SEND:
    - Out_Valid=1 and Out_Data=frame byte[idx].
    - Out_Data is held stable while Out_Ready=0.
    - Each accepting edge advances idx.
    - On acceptance of idx 17:
      - If the FIFO is non-empty, pop and load the next frame at that same edge with idx=0, giving no idle cycle between frames.
      - Otherwise go to IDLE.
- Frame layout, byte index:
  - 0: HEADER.
  - 1: flags byte = {5'b0, ovf, chg1, chg0}.
  - 2..9: Count0, little-endian.
  - 10..17: Count1, little-endian.
- ovf handling:
  - ovf = the Overflow value at the load edge.
  - Overflow is cleared on that same load edge, unless a drop also occurs on that edge, in which case it stays 1.
- Latency:
  - An input change before edge k is pushed at edge k.
  - If the FSM is IDLE, the pop happens at edge k+1, and byte 0 is valid after edge k+1.
- Edge cases:
  - Sample_En low: no pushes and Prev is frozen; the next high cycle compares against the stale Prev.
  - Counter reset to 0 is a change, provided Prev is nonzero.
  - Both counters changing on the same cycle produce a single entry with flags=2'b11.

Decomposition:
- Shared package holds:
  - FRAME_BYTES=18, HDR_DEFAULT=8'hA5.
  - Flag bit positions OVF_BIT=2, CHG1_BIT=1, CHG0_BIT=0.
  - FSM state encoding: IDLE, SEND.
- One natural sub-module: snap_fifo (parameterised width/depth synchronous FIFO with level output), instantiated with width 130.

Test Plan:
- Reset release, Sample_En=1, Count0 steps 0->1 with Out_Ready=1:
  - Exactly one frame: A5 01 01 00 00 00 00 00 00 00 00 00 00 00 00 00 00 00.
  - Byte 0 is valid two edges after the change.
- Count0=5 and Count1=2 change on the same cycle: flags byte 03, byte 2 = 05, byte 10 = 02.
- Out_Ready=0 held while Count0 increments every cycle for 10 cycles (DEPTH=4):
  - Fifo_Level saturates at 4 and Overflow=1.
  - After releasing Out_Ready, the frame loaded in SEND before saturation has flags bit2=0.
  - The first frame loaded after the drops has flags bit2=1, and Overflow clears.
- Out_Ready toggled 1/0 every cycle mid-frame: Out_Data holds whenever Out_Ready=0; all 18 bytes arrive in order with none duplicated.
- Two queued entries: the last byte of frame 1 and byte 0 of frame 2 appear on consecutive edges with Out_Valid continuously 1.
- Reset asserted asynchronously at frame byte 7:
  - Out_Valid drops immediately and Fifo_Level=0.
  - After release, no residual bytes are sent until a new change occurs.
